fp_mult_arbiter: RTL and testbench

Shares one latency-insensitive pipelined FP32 multiplier (ready/valid, in-order, `STAGES` deep) among `NUM_REQ` requesters. Each requester has its own ready/valid request and response channel. The block arbitrates issue slots round-robin, records each issued requester ID in an in-order tag FIFO, and steers each multiplier result and its flags back to the requester that issued it. It sits between client datapaths and the multiplier wrapper and adds no latency of its own.

---
 rtl/fp_mult_arbiter.sv | 138 +++++++++++++
 tb/tb_fp_mult_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: shares one pipelined FP32 multiplier among NUM_REQ clients.
// Define FP_MULT_ARB_FIXED_PRIO_EN for fixed lowest-index priority arbitration.
module fp_mult_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 8,
  parameter int STAGES    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [32*NUM_REQ-1:0]        req_a,
  input  logic [32*NUM_REQ-1:0]        req_b,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic [31:0]                  resp_result,
  output logic [2:0]                   resp_flags,
  output logic [31:0]                  m_a,
  output logic [31:0]                  m_b,
  output logic                         m_valid,
  input  logic                         m_ready,
  input  logic [31:0]                  m_result,
  input  logic                         m_exception,
  input  logic                         m_overflow,
  input  logic                         m_underflow,
  input  logic                         m_valid_out,
  output logic                         m_ready_in,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         proto_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(TAG_DEPTH);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] winner;
  logic [IW-1:0] head;
  logic          any_req;
  logic          tag_full;
  logic          tag_empty;
  logic          push;
  logic          pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [IW-1:0] tags [TAG_DEPTH];

  assign tag_full  = (count == DEPTH);
  assign tag_empty = (count == '0);
  assign head      = tags[rd_ptr];

  // Pick the first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    winner  = rr_ptr;
    any_req = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        winner  = idx[IW-1:0];
        any_req = 1'b1;
      end
    end
  end

  // Issue side: steer winner operands and grant when the multiplier takes them.
  always_comb begin
    m_valid   = any_req && !tag_full && !reset;
    m_a       = '0;
    m_b       = '0;
    req_ready = '0;
    if (m_valid) begin
      m_a = req_a[32*int'(winner) +: 32];
      m_b = req_b[32*int'(winner) +: 32];
    end
    if (m_valid && m_ready) req_ready[winner] = 1'b1;
  end

  assign push = m_valid && m_ready;

  // Return side: route the in-order result to the requester at the tag head.
  always_comb begin
    resp_valid = '0;
    m_ready_in = !tag_empty && resp_ready[head] && !reset;
    if (m_valid_out && !tag_empty && !reset) resp_valid[head] = 1'b1;
  end

  assign pop         = m_valid_out && m_ready_in;
  assign resp_result = m_result;
  assign resp_flags  = {m_exception, m_overflow, m_underflow};
  assign outstanding = count;

`ifdef FP_MULT_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  // Advance the round-robin pointer past each accepted winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (push) begin
      if (int'(winner) == NUM_REQ - 1) rr_ptr <= '0;
      else rr_ptr <= winner + 1'b1;
    end
  end
`endif

  // Tag storage holds issuer IDs; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= winner;
  end

  // Tag FIFO pointers, outstanding count and sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (m_valid_out && tag_empty) proto_err <= 1'b1;
    end
  end

  a_depth: assert property (@(posedge clk) disable iff (reset)
    TAG_DEPTH >= 2*STAGES + 2);
  a_count: assert property (@(posedge clk) disable iff (reset)
    count <= DEPTH);

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: random and directed checks of fp_mult_arbiter
// against a queue-based reference model and a behavioural multiplier.
module tb_fp_mult_arbiter;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int S  = 2;
  localparam int OW = $clog2(D) + 1;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [31:0]     resp_result;
  logic [2:0]      resp_flags;
  logic [31:0]     m_a;
  logic [31:0]     m_b;
  logic            m_valid;
  logic            m_ready;
  logic [31:0]     m_result;
  logic            m_exception;
  logic            m_overflow;
  logic            m_underflow;
  logic            m_valid_out;
  logic            m_ready_in;
  logic [OW-1:0]   outstanding;
  logic            proto_err;

  fp_mult_arbiter #(.NUM_REQ(N), .TAG_DEPTH(D), .STAGES(S)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .m_a(m_a), .m_b(m_b), .m_valid(m_valid), .m_ready(m_ready),
    .m_result(m_result), .m_exception(m_exception),
    .m_overflow(m_overflow), .m_underflow(m_underflow),
    .m_valid_out(m_valid_out), .m_ready_in(m_ready_in),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Simple normal-range FP32 multiply with truncation: {exc,ovf,unf,result}.
  function automatic logic [34:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    logic [47:0] m;
    logic [22:0] f;
    logic [31:0] r;
    logic s, x, o, u;
    int e;
    s = a[31] ^ b[31];
    x = (a[30:23] == 8'hff) || (b[30:23] == 8'hff);
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      f = m[46:24];
      e++;
    end else begin
      f = m[45:23];
    end
    o = !x && (e >= 255);
    u = !x && (e <= 0);
    if (x)      r = {s, 8'hff, 23'h400000};
    else if (o) r = {s, 8'hff, 23'h0};
    else if (u) r = {s, 31'h0};
    else        r = {s, e[7:0], f};
    return {x, o, u, r};
  endfunction

  // stimulus knobs
  logic [N-1:0]    rv;
  logic [N-1:0]    rsp;
  logic [32*N-1:0] ra;
  logic [32*N-1:0] rb;
  bit              mr_en;
  bit              force_mvo;

  // behavioural multiplier: in-order queue, result visible S edges after issue
  logic [34:0] mq_v[$];
  int          mq_age[$];

  // reference model: in-order list of (requester, expected result)
  typedef struct {
    int          id;
    logic [34:0] v;
  } ent_t;
  ent_t mdl[$];
  int   rr;
  bit   perr;

  // per-cycle expectations and captured handshakes
  int           w;
  int           hid;
  bit           e_mv, e_push, e_pop, e_mri, mt;
  logic [N-1:0] e_rr, e_rv;
  bit           dpush, dpop, mvo;
  logic [31:0]  da, db;

  task automatic eval();
    req_valid   = rv;
    req_a       = ra;
    req_b       = rb;
    resp_ready  = rsp;
    m_valid_out = ((mq_v.size() > 0) && (mq_age[0] >= S)) || force_mvo;
    if (mq_v.size() > 0)
      {m_exception, m_overflow, m_underflow, m_result} = mq_v[0];
    else
      {m_exception, m_overflow, m_underflow, m_result} = '0;
    #1;
    m_ready = mr_en && (mq_v.size() < D);
    #1;
    w = 0;
    for (int k = N - 1; k >= 0; k--)
      if (rv[(rr + k) % N]) w = (rr + k) % N;
    mt     = (mdl.size() == 0);
    hid    = mt ? 0 : mdl[0].id;
    e_mv   = (rv != 0) && (mdl.size() < D);
    e_push = e_mv && m_ready;
    e_rr   = e_push ? (N'(1) << w) : '0;
    e_rv   = (m_valid_out && !mt) ? (N'(1) << hid) : '0;
    e_mri  = !mt && rsp[hid];
    e_pop  = m_valid_out && e_mri;
    check("req_ready", req_ready, e_rr);
    check("m_valid", m_valid, e_mv);
    check("resp_valid", resp_valid, e_rv);
    check("m_ready_in", m_ready_in, e_mri);
    check("outstanding", outstanding, mdl.size());
    check("proto_err", proto_err, perr);
    if (e_mv) begin
      check("m_a", m_a, ra[32*w +: 32]);
      check("m_b", m_b, rb[32*w +: 32]);
    end
    if (e_rv != 0) begin
      check("resp_result", resp_result, mdl[0].v[31:0]);
      check("resp_flags", resp_flags, mdl[0].v[34:32]);
    end
    dpush = m_valid && m_ready;
    dpop  = m_valid_out && m_ready_in;
    mvo   = m_valid_out;
    da    = m_a;
    db    = m_b;
  endtask

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
    if (dpop && mq_v.size() > 0) begin
      void'(mq_v.pop_front());
      void'(mq_age.pop_front());
    end
    foreach (mq_age[i]) mq_age[i]++;
    if (dpush) begin
      mq_v.push_back(fmul(da, db));
      mq_age.push_back(1);
    end
    if (mvo && mt) perr = 1'b1;
    if (e_pop) void'(mdl.pop_front());
    if (e_push) begin
      mdl.push_back('{w, fmul(ra[32*w +: 32], rb[32*w +: 32])});
`ifndef FP_MULT_ARB_FIXED_PRIO_EN
      rr = (w + 1) % N;
`endif
    end
  endtask

  task automatic cycle();
    eval();
    advance();
  endtask

  task automatic drain();
    rv  = '0;
    rsp = '1;
    mr_en = 1'b1;
    for (int i = 0; i < 60 && (mdl.size() != 0 || mq_v.size() != 0); i++)
      cycle();
    check("drain", outstanding, 0);
  endtask

  // Called at a negedge; checks outputs right after reset rises.
  task automatic do_reset();
    rv = '1;
    req_valid = rv;
    force_mvo = 1'b0;
    m_valid_out = 1'b0;
    m_ready = 1'b1;
    resp_ready = '1;
    mq_v.delete();
    mq_age.delete();
    reset = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_m_ready_in", m_ready_in, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_proto_err", proto_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mdl.delete();
    rr   = 0;
    perr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rv = '0; rsp = '1; ra = '0; rb = '0;
    mr_en = 1'b1; force_mvo = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = '1;
    m_ready = 1'b1; m_valid_out = 1'b0; m_result = '0;
    m_exception = 1'b0; m_overflow = 1'b0; m_underflow = 1'b0;
    rr = 0; perr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    do_reset();

`ifndef FP_MULT_ARB_FIXED_PRIO_EN
    // all four requesting: grants rotate 0,1,2,3,0
    rv = '1;
    for (int k = 0; k < 5; k++) begin
      eval();
      check("rr_grant", req_ready, 4'b0001 << (k % 4));
      advance();
    end
`else
    // fixed priority: requester 1 always beats requester 2
    rv = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      eval();
      check("fixed_grant", req_ready, 4'b0010);
      advance();
    end
`endif
    drain();

    // 2.0 * 3.0 from requester 2
    rv = 4'b0100;
    ra[95:64] = 32'h40000000;
    rb[95:64] = 32'h40400000;
    cycle();
    rv = '0;
    cycle();
    eval();
    check("mul_resp_valid", resp_valid, 4'b0100);
    check("mul_result", resp_result, 32'h40C00000);
    check("mul_flags", resp_flags, 3'b000);
    advance();
    drain();

    // issue 1, 3, 1 with requester 3 stalled: in-order blocking
    rsp = 4'b0111;
    rv = 4'b0010; cycle();
    rv = 4'b1000; cycle();
    rv = 4'b0010; cycle();
    rv = '0;
    repeat (10) cycle();
    eval();
    check("hol_outstanding", outstanding, 2);
    check("hol_resp_valid", resp_valid, 4'b1000);
    advance();
    drain();

    // fill the tag FIFO, then free one slot
    rsp = '0;
    rv = '1;
    repeat (10) cycle();
    eval();
    check("full_outstanding", outstanding, 8);
    check("full_req_ready", req_ready, 0);
    advance();
    rsp = '1;
    cycle();
    rsp = '0;
    eval();
    check("refill_outstanding", outstanding, 7);
    check("refill_grant", req_ready != 0, 1);
    advance();
    drain();

    // stray multiplier output with nothing outstanding
    force_mvo = 1'b1;
    eval();
    check("perr_resp_valid", resp_valid, 0);
    check("perr_m_ready_in", m_ready_in, 0);
    advance();
    force_mvo = 1'b0;
    eval();
    check("perr_sticky", proto_err, 1);
    advance();

    // traffic then reset mid-stream
    rsp = 4'b0011;
    rv = '1;
    repeat (5) cycle();
    do_reset();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rv = N'($urandom);
      for (int i = 0; i < N; i++) begin
        ra[32*i +: 32] = $urandom;
        rb[32*i +: 32] = $urandom;
      end
      for (int i = 0; i < N; i++) rsp[i] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) rsp = '0;
      mr_en = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
